// File: rtl/rw_reg_wr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the register write arbiter.
package rw_reg_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int unsigned RR_MAX   = 8;
    localparam int unsigned RR_IDX_W = 3;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First asserted valid at or above ptr, wrapping modulo n (n <= RR_MAX).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !r.found && valid[j[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rw_reg_wr_arbiter_if.sv
// Multi-requester valid/ready write request bus, flattened per requester.
interface rw_reg_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ-1:0]            REQ_LOCK;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_READY;

    modport master (output REQ_VALID, REQ_LOCK, REQ_ADDR, REQ_DATA, input REQ_READY);
    modport slave  (input REQ_VALID, REQ_LOCK, REQ_ADDR, REQ_DATA, output REQ_READY);
endinterface

// File: rtl/rw_reg_wr_arbiter_bank.sv
// Bank of RW_REG registers sharing one write-data bus, selected by per-register WEN.
module RW_REG #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          HAS_RESET  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] VALUE_IN,
    output logic [DATA_WIDTH-1:0] VALUE_OUT
);
    if (HAS_RESET) begin : g_rst
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN)   VALUE_OUT <= '0;
            else if (WEN) VALUE_OUT <= VALUE_IN;
        end
    end else begin : g_nrst
        logic unused_rstn;
        always_comb unused_rstn = RSTN;
        always_ff @(posedge CLK) begin
            if (WEN) VALUE_OUT <= VALUE_IN;
        end
    end
endmodule

module rw_reg_wr_arbiter_bank #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REGS-1:0]            wen,
    input  logic [DATA_WIDTH-1:0]          value_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        RW_REG #(.DATA_WIDTH(DATA_WIDTH), .HAS_RESET(1'b1)) u_reg (
            .CLK      (clk),
            .RSTN     (rstn),
            .WEN      (wen[i]),
            .VALUE_IN (value_in),
            .VALUE_OUT(regs_out[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: rtl/rw_reg_wr_arbiter.sv
// Round-robin write arbiter with bounded lock bursts in front of an RW_REG bank.
module rw_reg_wr_arbiter
    import rw_reg_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned NUM_REGS    = 8,
    parameter  int unsigned MAX_LOCK    = 16,
    localparam int unsigned ADDR_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned OW          = $clog2(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           RST,
    rw_reg_wr_arbiter_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT,
    output logic                           BUSY,
    output logic [OW-1:0]                  OWNER,
    output logic                           ADDR_ERR
);
    arb_state_t            state, state_nxt;
    logic [OW-1:0]         ptr, ptr_nxt, owner, owner_nxt, winner;
    logic [7:0]            lock_cnt, lock_cnt_nxt, cnt_inc;
    logic [NUM_REQ-1:0]    ready;
    logic                  xfer, in_range, rel, addr_err;
    logic [RR_MAX-1:0]     valid_pad;
    rr_pick_t              pick;
    logic                  unused_pick;
    logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REGS-1:0]   wen;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + OW'(1);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_a[i] = bus.REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_a[i] = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        valid_pad              = '0;
        valid_pad[NUM_REQ-1:0] = bus.REQ_VALID;
        pick                   = rr_pick(valid_pad, RR_IDX_W'(ptr), NUM_REQ);
        unused_pick            = ^pick.idx;
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        ready        = '0;
        rel          = 1'b0;
        wen          = '0;
        winner       = (state == ARB_LOCKED) ? owner : pick.idx[OW-1:0];
        cnt_inc      = lock_cnt + 8'd1;

        if (!RST) begin
            case (state)
                ARB_IDLE:   if (pick.found) ready[winner] = 1'b1;
                ARB_LOCKED: if (32'(lock_cnt) < MAX_LOCK) ready[owner] = bus.REQ_VALID[owner];
            endcase
        end

        xfer     = |(ready & bus.REQ_VALID);
        win_addr = addr_a[winner];
        win_data = data_a[winner];
        in_range = 32'(win_addr) < NUM_REGS;

        case (state)
            ARB_IDLE: begin
                if (xfer) begin
                    if (bus.REQ_LOCK[winner]) begin
                        state_nxt    = ARB_LOCKED;
                        owner_nxt    = winner;
                        lock_cnt_nxt = 8'd1;
                    end else begin
                        ptr_nxt = wrap_inc(winner);
                    end
                end
            end
            ARB_LOCKED: begin
                // Count already at the limit only happens with MAX_LOCK==1: leave with no grant.
                if (32'(lock_cnt) >= MAX_LOCK) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    lock_cnt_nxt = cnt_inc;
                    rel          = !bus.REQ_LOCK[owner] || (32'(cnt_inc) >= MAX_LOCK);
                end else if (!bus.REQ_VALID[owner] && !bus.REQ_LOCK[owner]) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    state_nxt    = ARB_IDLE;
                    ptr_nxt      = wrap_inc(owner);
                    owner_nxt    = '0;
                    lock_cnt_nxt = '0;
                end
            end
        endcase

        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wen[i] = xfer && in_range && (32'(win_addr) == i);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            addr_err <= xfer && !in_range;
        end
    end

    always_comb begin
        bus.REQ_READY = ready;
        BUSY          = (state == ARB_LOCKED);
        OWNER         = owner;
        ADDR_ERR      = addr_err;
    end

    rw_reg_wr_arbiter_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_bank (
        .clk     (CLK),
        .rstn    (~RST),
        .wen     (wen),
        .value_in(win_data),
        .regs_out(REGS_OUT)
    );
endmodule

// File: tb/tb_rw_reg_wr_arbiter.sv
// Directed bench: table of per-cycle vectors plus hand sequences for reset and MAX_LOCK=1.
module tb_rw_reg_wr_arbiter;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    rw_reg_wr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    rw_reg_wr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    logic [6*DW-1:0] regs_a;
    logic            busy_a, err_a;
    logic [1:0]      owner_a;
    logic [8*DW-1:0] regs_b;
    logic            busy_b, err_b;
    logic [1:0]      owner_b;

    rw_reg_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_REGS(6), .MAX_LOCK(4)) dut_a (
        .CLK(CLK), .RST(RST), .bus(ifa.slave),
        .REGS_OUT(regs_a), .BUSY(busy_a), .OWNER(owner_a), .ADDR_ERR(err_a)
    );

    rw_reg_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_REGS(8), .MAX_LOCK(1)) dut_b (
        .CLK(CLK), .RST(RST), .bus(ifb.slave),
        .REGS_OUT(regs_b), .BUSY(busy_b), .OWNER(owner_b), .ADDR_ERR(err_b)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [11:0] addr;
        logic [63:0] data;
        logic [3:0]  ready;
        logic        busy;
        logic [1:0]  owner;
        logic        err;
        int unsigned ridx;
        logic [15:0] rval;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [11:0] A(input logic [2:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] D(input logic [15:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [15:0] rega(input int unsigned i);
        return regs_a[i*DW +: DW];
    endfunction

    function automatic logic [15:0] regb(input int unsigned i);
        return regs_b[i*DW +: DW];
    endfunction

    task automatic add(input logic [3:0] v, l, input logic [11:0] a, input logic [63:0] d,
                       input logic [3:0] r, input logic b, input logic [1:0] o, input logic e,
                       input int unsigned ri, input logic [15:0] rv);
        vec_t t;
        t.valid = v; t.lock = l; t.addr = a; t.data = d;
        t.ready = r; t.busy = b; t.owner = o; t.err = e; t.ridx = ri; t.rval = rv;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] v, l, input logic [11:0] a, input logic [63:0] d);
        ifa.REQ_VALID = v; ifa.REQ_LOCK = l; ifa.REQ_ADDR = a; ifa.REQ_DATA = d;
    endtask

    task automatic drive_b(input logic [3:0] v, l, input logic [11:0] a, input logic [63:0] d);
        ifb.REQ_VALID = v; ifb.REQ_LOCK = l; ifb.REQ_ADDR = a; ifb.REQ_DATA = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [11:0] sa;
        logic [15:0] exp_regs [6];
        sa = A(3'd3, 3'd2, 3'd1, 3'd0);

        // ptr walk 0..3, wrap
        add(4'b1111, 4'b0000, sa, D(16'h13, 16'h12, 16'h11, 16'h10), 4'b0001, 0, 0, 0, 0, 16'h0010);
        add(4'b1111, 4'b0000, sa, D(16'h13, 16'h12, 16'h11, 16'h10), 4'b0010, 0, 0, 0, 1, 16'h0011);
        add(4'b1111, 4'b0000, sa, D(16'h13, 16'h12, 16'h11, 16'h10), 4'b0100, 0, 0, 0, 2, 16'h0012);
        add(4'b1111, 4'b0000, sa, D(16'h13, 16'h12, 16'h11, 16'h10), 4'b1000, 0, 0, 0, 3, 16'h0013);
        add(4'b1111, 4'b0000, sa, D(16'h13, 16'h12, 16'h11, 16'h10), 4'b0001, 0, 0, 0, 0, 16'h0010);
        add(4'b1111, 4'b0000, sa, D(16'h13, 16'h12, 16'h11, 16'h10), 4'b0010, 0, 0, 0, 1, 16'h0011);
        // ptr=2 with only 0 and 3 valid
        add(4'b1001, 4'b0000, sa, D(16'h23, 16'h22, 16'h21, 16'h20), 4'b1000, 0, 0, 0, 3, 16'h0023);
        add(4'b1001, 4'b0000, sa, D(16'h23, 16'h22, 16'h21, 16'h20), 4'b0001, 0, 0, 0, 0, 16'h0020);
        // requester 1 locked burst of 3
        add(4'b0111, 4'b0010, sa, D(16'h33, 16'h32, 16'h31, 16'h30), 4'b0010, 1, 1, 0, 1, 16'h0031);
        add(4'b0111, 4'b0010, sa, D(16'h43, 16'h42, 16'h41, 16'h40), 4'b0010, 1, 1, 0, 1, 16'h0041);
        add(4'b0111, 4'b0000, sa, D(16'h53, 16'h52, 16'h51, 16'h50), 4'b0010, 0, 0, 0, 1, 16'h0051);
        add(4'b0101, 4'b0000, sa, D(16'h63, 16'h62, 16'h61, 16'h60), 4'b0100, 0, 0, 0, 2, 16'h0062);
        // requester 0 lock held for 6 writes, MAX_LOCK=4 forces release
        add(4'b0011, 4'b0001, sa, D(16'h0, 16'h0, 16'h81, 16'h70), 4'b0001, 1, 0, 0, 0, 16'h0070);
        add(4'b0011, 4'b0001, sa, D(16'h0, 16'h0, 16'h81, 16'h71), 4'b0001, 1, 0, 0, 0, 16'h0071);
        add(4'b0011, 4'b0001, sa, D(16'h0, 16'h0, 16'h81, 16'h72), 4'b0001, 1, 0, 0, 0, 16'h0072);
        add(4'b0011, 4'b0001, sa, D(16'h0, 16'h0, 16'h81, 16'h73), 4'b0001, 0, 0, 0, 0, 16'h0073);
        add(4'b0011, 4'b0001, sa, D(16'h0, 16'h0, 16'h81, 16'h74), 4'b0010, 0, 0, 0, 1, 16'h0081);
        add(4'b0011, 4'b0001, sa, D(16'h0, 16'h0, 16'h81, 16'h74), 4'b0001, 1, 0, 0, 0, 16'h0074);
        add(4'b0011, 4'b0000, sa, D(16'h0, 16'h0, 16'h81, 16'h75), 4'b0001, 0, 0, 0, 0, 16'h0075);
        // out-of-range address 7, then boundary address 5
        add(4'b0100, 4'b0000, A(3'd3, 3'd7, 3'd1, 3'd0), D(16'h0, 16'hdead, 16'h0, 16'h0),
            4'b0100, 0, 0, 1, 2, 16'h0062);
        add(4'b0000, 4'b0000, sa, D(16'h0, 16'h0, 16'h0, 16'h0), 4'b0000, 0, 0, 0, 2, 16'h0062);
        add(4'b1000, 4'b0000, A(3'd5, 3'd2, 3'd1, 3'd0), D(16'h55, 16'h0, 16'h0, 16'h0),
            4'b1000, 0, 0, 0, 5, 16'h0055);
        // owner idle with lock held, then drop of valid+lock releases
        add(4'b0001, 4'b0001, A(3'd3, 3'd2, 3'd1, 3'd4), D(16'h0, 16'h0, 16'h0, 16'h44),
            4'b0001, 1, 0, 0, 4, 16'h0044);
        add(4'b0010, 4'b0001, sa, D(16'h0, 16'h0, 16'h0, 16'h0), 4'b0000, 1, 0, 0, 4, 16'h0044);
        add(4'b0010, 4'b0000, sa, D(16'h0, 16'h0, 16'h0, 16'h0), 4'b0000, 0, 0, 0, 4, 16'h0044);
        add(4'b0010, 4'b0000, sa, D(16'h0, 16'h0, 16'h91, 16'h0), 4'b0010, 0, 0, 0, 1, 16'h0091);

        // reset state, READY held low while RST high even with requests pending
        RST = 1'b1;
        drive_a(4'b1111, 4'b0000, sa, '0);
        drive_b(4'b0000, 4'b0000, sa, '0);
        #12;
        chk("rst_ready", ifa.REQ_READY, 4'b0000);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_owner", owner_a, 2'd0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_reg0", rega(0), 16'h0);
        chk("rst_reg5", rega(5), 16'h0);
        drive_a(4'b0000, 4'b0000, sa, '0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].valid, vecs[i].lock, vecs[i].addr, vecs[i].data);
            @(negedge CLK);
            chk($sformatf("v%0d ready", i), ifa.REQ_READY, vecs[i].ready);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d busy", i), busy_a, vecs[i].busy);
            chk($sformatf("v%0d owner", i), owner_a, vecs[i].owner);
            chk($sformatf("v%0d addr_err", i), err_a, vecs[i].err);
            chk($sformatf("v%0d reg%0d", i, vecs[i].ridx), rega(vecs[i].ridx), vecs[i].rval);
        end

        exp_regs = '{16'h0075, 16'h0091, 16'h0062, 16'h0023, 16'h0044, 16'h0055};
        for (int i = 0; i < 6; i++) chk($sformatf("snap reg%0d", i), rega(i), exp_regs[i]);

        // reset in the middle of a lock by requester 2
        drive_a(4'b0100, 4'b0100, sa, D(16'h0, 16'ha2, 16'h0, 16'h0));
        @(negedge CLK);
        chk("lk2 ready", ifa.REQ_READY, 4'b0100);
        @(posedge CLK);
        #1;
        chk("lk2 busy", busy_a, 1'b1);
        chk("lk2 owner", owner_a, 2'd2);
        chk("lk2 reg2", rega(2), 16'h00a2);
        #2;
        RST = 1'b1;
        #1;
        chk("arst busy", busy_a, 1'b0);
        chk("arst owner", owner_a, 2'd0);
        chk("arst ready", ifa.REQ_READY, 4'b0000);
        for (int i = 0; i < 6; i++) chk($sformatf("arst reg%0d", i), rega(i), 16'h0);
        @(negedge CLK);
        RST = 1'b0;
        drive_a(4'b1111, 4'b0000, sa, D(16'hb3, 16'hb2, 16'hb1, 16'hb0));
        #1;
        chk("post ready", ifa.REQ_READY, 4'b0001);
        @(posedge CLK);
        #1;
        chk("post reg0", rega(0), 16'h00b0);
        chk("post busy", busy_a, 1'b0);
        drive_a(4'b0000, 4'b0000, sa, '0);

        // MAX_LOCK=1: lock request is one transfer plus a one-cycle BUSY pulse
        drive_b(4'b0001, 4'b0001, A(3'd0, 3'd0, 3'd0, 3'd2), D(16'h0, 16'h0, 16'h0, 16'hbeef));
        @(negedge CLK);
        chk("ml1 ready", ifb.REQ_READY, 4'b0001);
        @(posedge CLK);
        #1;
        chk("ml1 busy", busy_b, 1'b1);
        chk("ml1 owner", owner_b, 2'd0);
        chk("ml1 reg2", regb(2), 16'hbeef);
        drive_b(4'b0000, 4'b0000, sa, '0);
        @(negedge CLK);
        chk("ml1 ready2", ifb.REQ_READY, 4'b0000);
        @(posedge CLK);
        #1;
        chk("ml1 busy2", busy_b, 1'b0);
        drive_b(4'b0011, 4'b0000, sa, D(16'h0, 16'h0, 16'hc1, 16'hc0));
        @(negedge CLK);
        chk("ml1 ptr", ifb.REQ_READY, 4'b0010);
        @(posedge CLK);
        #1;
        chk("ml1 reg1", regb(1), 16'h00c1);
        chk("ml1 err", err_b, 1'b0);
        drive_b(4'b0000, 4'b0000, sa, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
